// File: rtl/grid_seq_pkg.sv
// Shared definitions for the trap-grid sequencer: FSM state encoding and
// the phase-select codes used to pick which dwell is loaded into the timer.
package grid_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRIME  = 3'd1,
    S_SPREAD = 3'd2,
    S_ADV    = 3'd3,
    S_FLUSH  = 3'd4,
    S_DONE   = 3'd5,
    S_ABORT  = 3'd6
  } state_t;

  typedef logic [1:0] phase_t;

  localparam phase_t PH_PRIME  = 2'd0;
  localparam phase_t PH_SPREAD = 2'd1;
  localparam phase_t PH_ADV    = 2'd2;
  localparam phase_t PH_FLUSH  = 2'd3;

endpackage

// File: rtl/grid_seq_dwell_timer.sv
// Loadable down-counter shared by every phase of the sequencer.
// A load of 0 is clamped to 1 so every phase lasts at least one cycle.
// expired is high during the last cycle of the loaded dwell only.
module dwell_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] cnt;

  // Count register: load wins over counting; stops at zero after expiry.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= (load_val == '0) ? CNT_W'(1) : load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == CNT_W'(1));

endmodule

// File: rtl/grid_seq.sv
// Trap-grid valve sequencer. Routes one of N_IN fluid inputs through a
// binary valve mux, then primes, spreads and advances fluid through
// N_STAGE cascaded trap stages (one stage at a time or all at once),
// and finally flushes. One dwell timer is reused for every phase.
//
// Handshake: start is a level request honoured only in IDLE (and only when
// abort is low); busy is high for the whole run; done or aborted is a
// single-cycle pulse that ends it. No backpressure exists.
module grid_seq
  import grid_seq_pkg::*;
#(
  parameter int N_IN    = 8,
  parameter int N_STAGE = 8,
  parameter int CNT_W   = 16,
  localparam int SW     = $clog2(N_IN),
  localparam int STW    = $clog2(N_STAGE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 mode,
  input  logic [SW-1:0]        in_sel,
  input  logic [CNT_W-1:0]     t_prime,
  input  logic [CNT_W-1:0]     t_spread,
  input  logic [CNT_W-1:0]     t_adv,
  input  logic [CNT_W-1:0]     t_flush,
  output logic [2*SW-1:0]      mux_ctl,
  output logic [N_STAGE-1:0]   lat_ctl,
  output logic [N_STAGE-1:0]   fwd_ctl,
  output logic [STW-1:0]       stage,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output state_t               dbg_state
);

  localparam logic [STW-1:0] LAST_STAGE = STW'(N_STAGE - 1);

  state_t           state_q, state_d;
  logic [STW-1:0]   stage_q, stage_d;
  logic             accept;
  logic             tmr_load;
  phase_t           load_ph;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_exp;

  // Run parameters captured at start. The prime dwell goes straight into
  // the timer on the accepting edge, so it needs no holding register.
  logic             mode_q;
  logic [SW-1:0]    sel_q;
  logic [CNT_W-1:0] ts_q, ta_q, tf_q;
  logic [2*SW-1:0]  mux_sel;

  dwell_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_exp)
  );

  // State and stage registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
    end
  end

  // Latch run parameters when a start is accepted; frozen for the whole run.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= 1'b0;
      sel_q  <= '0;
      ts_q   <= '0;
      ta_q   <= '0;
      tf_q   <= '0;
    end else if (accept) begin
      mode_q <= mode;
      sel_q  <= in_sel;
      ts_q   <= t_spread;
      ta_q   <= t_adv;
      tf_q   <= t_flush;
    end
  end

  // Next-state logic; abort outranks phase expiry in every busy state.
  always_comb begin
    state_d  = state_q;
    stage_d  = stage_q;
    accept   = 1'b0;
    tmr_load = 1'b0;
    load_ph  = PH_PRIME;
    case (state_q)
      S_IDLE: begin
        stage_d = '0;
        if (start && !abort) begin
          accept   = 1'b1;
          tmr_load = 1'b1;
          load_ph  = PH_PRIME;
          state_d  = S_PRIME;
        end
      end
      S_PRIME: begin
        if (abort) begin
          state_d = S_ABORT;
          stage_d = '0;
        end else if (tmr_exp) begin
          state_d  = S_SPREAD;
          tmr_load = 1'b1;
          load_ph  = PH_SPREAD;
        end
      end
      S_SPREAD: begin
        if (abort) begin
          state_d = S_ABORT;
          stage_d = '0;
        end else if (tmr_exp) begin
          state_d  = S_ADV;
          tmr_load = 1'b1;
          load_ph  = PH_ADV;
        end
      end
      S_ADV: begin
        if (abort) begin
          state_d = S_ABORT;
          stage_d = '0;
        end else if (tmr_exp) begin
          tmr_load = 1'b1;
          if (!mode_q && (stage_q != LAST_STAGE)) begin
            state_d = S_SPREAD;
            stage_d = stage_q + 1'b1;
            load_ph = PH_SPREAD;
          end else begin
            state_d = S_FLUSH;
            stage_d = '0;
            load_ph = PH_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (abort) begin
          state_d = S_ABORT;
          stage_d = '0;
        end else if (tmr_exp) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ABORT: state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        stage_d = '0;
      end
    endcase
  end

  // Dwell selection for the timer; prime is only loaded from IDLE, where the
  // live input is the value being captured.
  always_comb begin
    case (load_ph)
      PH_PRIME:  tmr_val = t_prime;
      PH_SPREAD: tmr_val = ts_q;
      PH_ADV:    tmr_val = ta_q;
      default:   tmr_val = tf_q;
    endcase
  end

  // Mux valve pattern: each level opens exactly one of its two lines.
  always_comb begin
    mux_sel = '0;
    for (int k = 0; k < SW; k++) begin
      mux_sel[2*k]   = ~sel_q[k];
      mux_sel[2*k+1] = sel_q[k];
    end
  end

  // Valve and status outputs decoded from the current state.
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    aborted = 1'b0;
    lat_ctl = '0;
    fwd_ctl = '0;
    mux_ctl = '0;
    case (state_q)
      S_PRIME: begin
        busy    = 1'b1;
        mux_ctl = mux_sel;
      end
      S_SPREAD: begin
        busy    = 1'b1;
        mux_ctl = mux_sel;
        if (mode_q) lat_ctl = '1;
        else        lat_ctl[stage_q] = 1'b1;
      end
      S_ADV: begin
        busy    = 1'b1;
        mux_ctl = mux_sel;
        if (mode_q) fwd_ctl = '1;
        else        fwd_ctl[stage_q] = 1'b1;
      end
      S_FLUSH: begin
        busy    = 1'b1;
        mux_ctl = mux_sel;
        fwd_ctl = '1;
      end
      S_DONE:  done    = 1'b1;
      S_ABORT: aborted = 1'b1;
      default: ;
    endcase
  end

  assign stage     = stage_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_grid_seq.sv
// Bench for grid_seq: builds the expected per-cycle output trace of each run
// from the phase rules, then compares the DUT cycle by cycle.
module tb_grid_seq;
  import grid_seq_pkg::*;

  localparam int N_IN    = 8;
  localparam int N_STAGE = 8;
  localparam int CNT_W   = 16;
  localparam int SW      = 3;
  localparam int STW     = 3;
  localparam int EW      = 3 + STW + 2*N_STAGE + 2*SW;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic               mode = 1'b0;
  logic [SW-1:0]      in_sel = '0;
  logic [CNT_W-1:0]   t_prime = '0, t_spread = '0, t_adv = '0, t_flush = '0;
  logic [2*SW-1:0]    mux_ctl;
  logic [N_STAGE-1:0] lat_ctl, fwd_ctl;
  logic [STW-1:0]     stage;
  logic               busy, done, aborted;
  state_t             dbg_state;

  grid_seq #(.N_IN(N_IN), .N_STAGE(N_STAGE), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
    .in_sel(in_sel), .t_prime(t_prime), .t_spread(t_spread), .t_adv(t_adv),
    .t_flush(t_flush), .mux_ctl(mux_ctl), .lat_ctl(lat_ctl), .fwd_ctl(fwd_ctl),
    .stage(stage), .busy(busy), .done(done), .aborted(aborted),
    .dbg_state(dbg_state)
  );

  logic [EW-1:0] obs_vec;
  assign obs_vec = {busy, done, aborted, stage, lat_ctl, fwd_ctl, mux_ctl};

  // scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  logic [EW-1:0] exp_q[$];

  function automatic logic [EW-1:0] mk(input logic b, input logic d,
                                       input logic a, input int stg,
                                       input logic [N_STAGE-1:0] lat,
                                       input logic [N_STAGE-1:0] fwd,
                                       input logic [2*SW-1:0] mx);
    logic [STW-1:0] s;
    s = stg[STW-1:0];
    return {b, d, a, s, lat, fwd, mx};
  endfunction

  function automatic logic [2*SW-1:0] mux_of(input int sel);
    logic [2*SW-1:0] r;
    r = '0;
    for (int k = 0; k < SW; k++) r[2*k +: 2] = sel[k] ? 2'b10 : 2'b01;
    return r;
  endfunction

  function automatic int eff(input int t);
    return (t == 0) ? 1 : t;
  endfunction

  function automatic int done_at(input logic md, input int tp, input int ts,
                                 input int ta, input int tf);
    int s;
    s = md ? 1 : N_STAGE;
    return 1 + eff(tp) + s * (eff(ts) + eff(ta)) + eff(tf);
  endfunction

  // Expected outputs for cycles 1.. of an uninterrupted run, plus one idle.
  task automatic build_trace(input logic md, input int sel, input int tp,
                             input int ts, input int ta, input int tf);
    logic [2*SW-1:0]    m;
    logic [N_STAGE-1:0] v;
    int                 ns;
    exp_q.delete();
    m  = mux_of(sel);
    ns = md ? 1 : N_STAGE;
    for (int c = 0; c < eff(tp); c++) exp_q.push_back(mk(1, 0, 0, 0, '0, '0, m));
    for (int s = 0; s < ns; s++) begin
      v = '0;
      if (md) v = '1; else v[s] = 1'b1;
      for (int c = 0; c < eff(ts); c++)
        exp_q.push_back(mk(1, 0, 0, md ? 0 : s, v, '0, m));
      for (int c = 0; c < eff(ta); c++)
        exp_q.push_back(mk(1, 0, 0, md ? 0 : s, '0, v, m));
    end
    for (int c = 0; c < eff(tf); c++) exp_q.push_back(mk(1, 0, 0, 0, '0, '1, m));
    exp_q.push_back(mk(0, 1, 0, 0, '0, '0, '0));
    exp_q.push_back('0);
  endtask

  task automatic check_vec(input string tag, input logic [EW-1:0] obs,
                           input logic [EW-1:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // driver: one run, with optional abort / reset / stray start at a cycle
  task automatic run(input logic md, input int sel, input int tp, input int ts,
                     input int ta, input int tf, input int abort_at,
                     input int rst_at, input int poke_at, input string tag);
    int done_cyc;
    int n;
    build_trace(md, sel, tp, ts, ta, tf);
    if (abort_at > 0) begin
      while (exp_q.size() > abort_at) void'(exp_q.pop_back());
      exp_q.push_back(mk(0, 0, 1, 0, '0, '0, '0));
      exp_q.push_back('0);
    end
    if (rst_at > 0) begin
      while (exp_q.size() > rst_at) void'(exp_q.pop_back());
      exp_q.push_back('0);
      exp_q.push_back('0);
    end
    mode     = md;
    in_sel   = SW'(sel);
    t_prime  = CNT_W'(tp);
    t_spread = CNT_W'(ts);
    t_adv    = CNT_W'(ta);
    t_flush  = CNT_W'(tf);
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    mode     = 1'($urandom);
    in_sel   = SW'($urandom);
    t_prime  = CNT_W'($urandom_range(0, 9));
    t_spread = CNT_W'($urandom_range(0, 9));
    t_adv    = CNT_W'($urandom_range(0, 9));
    t_flush  = CNT_W'($urandom_range(0, 9));
    n = exp_q.size();
    done_cyc = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_vec($sformatf("%s_c%0d", tag, i + 1), obs_vec, exp_q[i]);
      if (done) done_cyc = i + 1;
      if (i == 0 && sel == 5) begin
        n_checks++;
        assert (mux_ctl === 6'b100110) else begin
          n_fail++;
          $error("FAIL %s_mux5: observed %b expected 100110", tag, mux_ctl);
        end
      end
      if (i + 1 == abort_at) abort = 1'b1;
      if (i + 1 == rst_at) rst = 1'b1;
      if (i + 1 == poke_at) begin
        start  = 1'b1;
        in_sel = SW'($urandom);
        mode   = 1'($urandom);
      end
      @(posedge clk); #1;
      abort = 1'b0;
      rst   = 1'b0;
      start = 1'b0;
    end
    if (abort_at == 0 && rst_at == 0)
      check_int({tag, "_done_cycle"}, done_cyc, done_at(md, tp, ts, ta, tf));
    else
      check_int({tag, "_no_done"}, done_cyc, 0);
  endtask

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // directed and random stimulus
  initial begin
    int md, sel, tp, ts, ta, tf, ab, blen;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_vec("reset_outputs", obs_vec, '0);
    n_checks++;
    assert (dbg_state === S_IDLE) else begin
      n_fail++;
      $error("FAIL reset_state: observed %0d expected %0d", dbg_state, S_IDLE);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // sequential run, stray start mid-run
    run(1'b0, 5, 2, 3, 1, 4, 0, 0, 10, "seq");
    check_int("seq_done_39", done_at(1'b0, 2, 3, 1, 4), 39);
    // broadcast run
    run(1'b1, 5, 2, 3, 1, 4, 0, 0, 0, "bcast");
    // all-zero dwells
    run(1'b0, 3, 0, 0, 0, 0, 0, 0, 0, "zero");
    // abort during stage-3 ADV (cycle 2 + 3*4 + 3 + 1 = 18)
    run(1'b0, 6, 2, 3, 1, 4, 18, 0, 0, "abort_adv3");

    // start together with abort in IDLE: ignored
    start = 1'b1; abort = 1'b1; in_sel = 3'd2;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_vec($sformatf("start_abort_idle_c%0d", i + 1), obs_vec, '0);
      n_checks++;
      assert (dbg_state === S_IDLE) else begin
        n_fail++;
        $error("FAIL start_abort_state: observed %0d expected %0d", dbg_state, S_IDLE);
      end
      @(posedge clk); #1;
    end

    // reset during FLUSH (cycles 35..38), then a normal run
    run(1'b0, 5, 2, 3, 1, 4, 0, 36, 0, "rst_flush");
    run(1'b1, 1, 1, 2, 1, 1, 0, 0, 0, "post_rst");

    // randomized runs, some aborted
    for (int r = 0; r < 8; r++) begin
      md  = $urandom_range(0, 1);
      sel = $urandom_range(0, N_IN - 1);
      tp  = $urandom_range(0, 3);
      ts  = $urandom_range(0, 3);
      ta  = $urandom_range(0, 3);
      tf  = $urandom_range(0, 3);
      blen = done_at(md[0], tp, ts, ta, tf) - 1;
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, blen) : 0;
      run(md[0], sel, tp, ts, ta, tf, ab, 0, $urandom_range(1, blen),
          $sformatf("rand%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
